// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced, already-synchronous button level into
// single-cycle press / release / long-press / auto-repeat pulses plus a held
// level. Every output is registered, so an event sampled at edge k is visible
// for the cycle following edge k.
// Optional feature: define BUTTON_AUTO_REPEAT_EN to generate repeat_pulse while
// the button stays long-held. When it is undefined, the repeat counter is not
// built and repeat_pulse is tied low.
module button_event_gen #(
  parameter int LONG_CYCLES   = 50_000_000,  // hold length before long_press, >= 2
  parameter int REPEAT_CYCLES = 10_000_000   // auto-repeat period once long-held, >= 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held,
  output logic was_long
);

  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  // INIT exists so that a button held through reset never produces a press:
  // the button must be seen released once before presses are accepted.
  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic press_q,   press_d;
  logic release_q, release_d;
  logic long_q,    long_d;
  logic held_q,    held_d;
  logic was_long_q, was_long_d;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             repeat_q,  repeat_d;
`endif

  // State and output registers; Reset is synchronous and overrides everything.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_INIT;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      held_q     <= 1'b0;
      was_long_q <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt_q  <= '0;
      repeat_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      held_q     <= held_d;
      was_long_q <= was_long_d;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
      repeat_q   <= repeat_d;
`endif
    end
  end

  // Next-state logic: release beats the long-press threshold on the same edge.
  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: begin
        if (!btn_level) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (btn_level) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (!btn_level)                    state_d = ST_IDLE;
        else if (hold_cnt_q == LONG_LAST)  state_d = ST_LONG_HELD;
      end
      ST_LONG_HELD: begin
        if (!btn_level) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Output and counter logic: next values of the registered pulses, held
  // level and hold / repeat counters, all derived from the current state.
  always_comb begin
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    held_d     = 1'b0;
    was_long_d = 1'b0;
    hold_cnt_d = hold_cnt_q;
`ifdef BUTTON_AUTO_REPEAT_EN
    repeat_d   = 1'b0;
    rep_cnt_d  = rep_cnt_q;
`endif
    unique case (state_q)
      ST_INIT: begin
        // Silent until the button has been seen released.
      end
      ST_IDLE: begin
        if (btn_level) begin
          press_d    = 1'b1;
          held_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end
      ST_PRESSED: begin
        if (!btn_level) begin
          release_d = 1'b1;
        end else begin
          held_d = 1'b1;
          if (hold_cnt_q == LONG_LAST) begin
            // Counter stays at its last value: it saturates instead of wrapping.
            long_d = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
            rep_cnt_d = '0;
`endif
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LONG_HELD: begin
        if (!btn_level) begin
          release_d  = 1'b1;
          was_long_d = 1'b1;
        end else begin
          held_d = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
          if (rep_cnt_q == REPEAT_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      default: begin
      end
    endcase
  end

  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign held          = held_q;
  assign was_long      = was_long_q;
`ifdef BUTTON_AUTO_REPEAT_EN
  assign repeat_pulse  = repeat_q;
`else
  assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Testbench for button_event_gen with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Expected outputs come from an event model that works from the number of
// edges since the press began; directed scenarios also check fixed edges.
module tb_button_event_gen;

  localparam int L = 8;
  localparam int R = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit AUTO_REP = 1'b1;
`else
  localparam bit AUTO_REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn;
  logic press, release_pulse, long_press, repeat_pulse, held, was_long;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Model state: armed = button seen released since reset; start = press edge.
  bit         m_armed   = 1'b0;
  bit         m_pressed = 1'b0;
  int         m_start   = 0;
  logic [5:0] exp_v;  // {press, release, long_press, repeat_pulse, held, was_long}

  button_event_gen #(
    .LONG_CYCLES   (L),
    .REPEAT_CYCLES (R)
  ) dut (
    .Clk           (clk),
    .Reset         (reset),
    .btn_level     (btn),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .was_long      (was_long)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] obs();
    return {press, release_pulse, long_press, repeat_pulse, held, was_long};
  endfunction

  // Expected outputs after the edge just taken, from the elapsed hold time.
  function automatic void model_edge(input logic b, input logic r);
    int d;
    exp_v = '0;
    if (r) begin
      m_armed   = 1'b0;
      m_pressed = 1'b0;
    end else if (!m_armed) begin
      if (!b) m_armed = 1'b1;
    end else if (!m_pressed) begin
      if (b) begin
        exp_v[5]  = 1'b1;
        exp_v[1]  = 1'b1;
        m_pressed = 1'b1;
        m_start   = edge_n;
      end
    end else begin
      d = edge_n - m_start;
      if (!b) begin
        exp_v[4]  = 1'b1;
        exp_v[0]  = (d > L);
        m_pressed = 1'b0;
      end else begin
        exp_v[1] = 1'b1;
        exp_v[3] = (d == L);
        exp_v[2] = AUTO_REP && (d > L) && (((d - L) % R) == 0);
      end
    end
  endfunction

  // Drive inputs mid-cycle, take one edge, update the model, sample 1 ns later.
  task automatic step(input logic b, input logic r);
    @(negedge clk);
    btn   = b;
    reset = r;
    @(posedge clk);
    edge_n++;
    model_edge(b, r);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if (obs() !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want %b", obs(), 6'b0);
    end
    for (int e = 1; e <= 4; e++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs() !== exp_v) begin
        failures++;
        $display("FAIL reset_idle edge %0d: got %b want %b", e, obs(), exp_v);
      end
    end
  endtask

  task automatic test_short_press();
    int presses = 0;
    for (int e = 1; e <= 16; e++) begin
      step(e >= 10 && e < 13, 1'b0);
      presses += press;
      checks++;
      if (obs() !== exp_v) begin
        failures++;
        $display("FAIL short_press edge %0d: got %b want %b", e, obs(), exp_v);
      end
      if (e == 13) begin
        checks++;
        if ({release_pulse, was_long, held} !== 3'b100) begin
          failures++;
          $display("FAIL short_release edge 13: got rel/wl/held=%b want 100",
                   {release_pulse, was_long, held});
        end
      end
    end
    checks++;
    if (presses != 1) begin
      failures++;
      $display("FAIL short_press_count: got %0d want 1", presses);
    end
  endtask

  task automatic test_long_hold();
    int longs = 0;
    int reps  = 0;
    for (int e = 1; e <= 34; e++) begin
      step(e >= 10 && e < 30, 1'b0);
      longs += long_press;
      reps  += repeat_pulse;
      checks++;
      if (obs() !== exp_v) begin
        failures++;
        $display("FAIL long_hold edge %0d: got %b want %b", e, obs(), exp_v);
      end
      if (e == 18) begin
        checks++;
        if (long_press !== 1'b1) begin
          failures++;
          $display("FAIL long_press_edge18: got %b want 1", long_press);
        end
      end
      if (e == 22 || e == 26) begin
        checks++;
        if (repeat_pulse !== AUTO_REP) begin
          failures++;
          $display("FAIL repeat_edge%0d: got %b want %b", e, repeat_pulse, AUTO_REP);
        end
      end
      if (e == 30) begin
        checks++;
        if ({release_pulse, was_long, repeat_pulse} !== 3'b110) begin
          failures++;
          $display("FAIL long_release edge 30: got rel/wl/rep=%b want 110",
                   {release_pulse, was_long, repeat_pulse});
        end
      end
    end
    checks++;
    if (longs != 1 || reps != (AUTO_REP ? 2 : 0)) begin
      failures++;
      $display("FAIL long_hold_counts: got long=%0d rep=%0d want long=1 rep=%0d",
               longs, reps, AUTO_REP ? 2 : 0);
    end
  endtask

  task automatic test_held_through_reset();
    int presses = 0;
    for (int e = 1; e <= 28; e++) begin
      step(!(e == 20 || e == 21 || e > 25), e <= 3);
      presses += press;
      checks++;
      if (obs() !== exp_v) begin
        failures++;
        $display("FAIL held_reset edge %0d: got %b want %b", e, obs(), exp_v);
      end
      if (e == 22) begin
        checks++;
        if (press !== 1'b1) begin
          failures++;
          $display("FAIL held_reset_press edge 22: got %b want 1", press);
        end
      end
    end
    checks++;
    if (presses != 1) begin
      failures++;
      $display("FAIL held_reset_press_count: got %0d want 1", presses);
    end
  endtask

  task automatic test_release_on_threshold();
    for (int e = 1; e <= 20; e++) begin
      step(e >= 10 && e < 18, 1'b0);
      checks++;
      if (obs() !== exp_v) begin
        failures++;
        $display("FAIL rel_threshold edge %0d: got %b want %b", e, obs(), exp_v);
      end
      if (e == 18) begin
        checks++;
        if ({release_pulse, long_press, was_long} !== 3'b100) begin
          failures++;
          $display("FAIL rel_threshold_edge18: got rel/long/wl=%b want 100",
                   {release_pulse, long_press, was_long});
        end
      end
    end
  endtask

  task automatic test_release_on_repeat();
    for (int e = 1; e <= 24; e++) begin
      step(e >= 10 && e < 22, 1'b0);
      checks++;
      if (obs() !== exp_v) begin
        failures++;
        $display("FAIL rel_repeat edge %0d: got %b want %b", e, obs(), exp_v);
      end
      if (e == 22) begin
        checks++;
        if ({release_pulse, repeat_pulse, was_long} !== 3'b101) begin
          failures++;
          $display("FAIL rel_repeat_edge22: got rel/rep/wl=%b want 101",
                   {release_pulse, repeat_pulse, was_long});
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    for (int e = 1; e <= 33; e++) begin
      step((e >= 10 && e <= 25) || (e >= 28 && e <= 30), e == 15);
      checks++;
      if (obs() !== exp_v) begin
        failures++;
        $display("FAIL reset_mid edge %0d: got %b want %b", e, obs(), exp_v);
      end
      if (e >= 15 && e <= 27) begin
        checks++;
        if (obs() !== 6'b0) begin
          failures++;
          $display("FAIL reset_mid_quiet edge %0d: got %b want 000000", e, obs());
        end
      end
      if (e == 28) begin
        checks++;
        if (press !== 1'b1) begin
          failures++;
          $display("FAIL reset_mid_repress edge 28: got %b want 1", press);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int presses  = 0;
    int releases = 0;
    for (int e = 1; e <= 18; e++) begin
      step(e >= 10 && e <= 15 && (e % 2 == 0), 1'b0);
      presses  += press;
      releases += release_pulse;
      checks++;
      if (obs() !== exp_v) begin
        failures++;
        $display("FAIL back_to_back edge %0d: got %b want %b", e, obs(), exp_v);
      end
      checks++;
      if (press === 1'b1 && release_pulse === 1'b1) begin
        failures++;
        $display("FAIL back_to_back_overlap edge %0d: got press=1 release=1 want not both", e);
      end
    end
    checks++;
    if (presses != 3 || releases != 3) begin
      failures++;
      $display("FAIL back_to_back_counts: got press=%0d release=%0d want 3/3",
               presses, releases);
    end
  endtask

  task automatic test_random();
    logic b   = 1'b0;
    int   run = 0;
    for (int e = 0; e < 3000; e++) begin
      if (run == 0) begin
        b   = ~b;
        run = b ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 6));
      end
      run--;
      step(b, $urandom_range(0, 299) == 0);
      checks++;
      if (obs() !== exp_v) begin
        failures++;
        $display("FAIL random edge %0d: got %b want %b", e, obs(), exp_v);
      end
    end
  endtask

  initial begin
    btn   = 1'b0;
    reset = 1'b1;
    test_reset();
    test_short_press();
    test_long_hold();
    test_held_through_reset();
    test_release_on_threshold();
    test_release_on_repeat();
    test_reset_mid_hold();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
